serial_adder_datapath: RTL
==========================

// Module: serial_adder_datapath
// PURPOSE
//  Bit-serial add datapath driven by the serial-adder sequencer's load / enable /
//  clear strobes. Captures two WIDTH-bit operands, adds one bit per enable
//  cycle LSB-first through a carry flip-flop, and assembles a WIDTH+1-bit sum.
//  Asserts done for one cycle after the final shift.
// PARAMETERS
//  WIDTH  10  operand width; one add needs exactly WIDTH+1 enable cycles (last = carry-out)
// PORTS
//  clk_i      in   1        clock; all state updates on rising edge
//  rst_i      in   1        asynchronous, active-high reset
//  clr_n_i    in   1        synchronous clear, active-low (sequencer rst_n)
//  load_i     in   1        capture a_i/b_i, start new add
//  enable_i   in   1        perform one bit-step
//  a_i        in   WIDTH    operand A, sampled only on load
//  b_i        in   WIDTH    operand B, sampled only on load
//  sum_o      out  WIDTH+1  sum register; valid when done_o=1, held in IDLE
//  sum_bit_o  out  1        sum bit produced by the current step (combinational, a0^b0^c)
//  busy_o     out  1        1 while in RUN
//  done_o     out  1        1-cycle pulse, state DONE
//  err_o      out  1        sticky: enable_i seen while not in RUN
// BEHAVIOUR
//  Regs: a_sr, b_sr [WIDTH], c (carry), sum_sr [WIDTH+1], cnt [0..WIDTH+1], state.
//  Reset (rst_i=1, async): state=IDLE; a_sr, b_sr, c, sum_sr, cnt = 0; all outputs 0.
//  Per-edge priority: clr_n_i=0 > load_i=1 > enable_i=1 > hold.
//  clr_n_i=0: same values as reset, applied synchronously; err_o cleared.
//  load_i=1 (any state): a_sr=a_i, b_sr=b_i, c=0, sum_sr=0, cnt=0, err_o=0, state=RUN.
//  FSM states:
//   IDLE: busy=0, done=0. load -> RUN. enable -> err_o=1, stay IDLE.
//   RUN:  busy=1. On enable: s=a_sr[0]^b_sr[0]^c; c=majority(a_sr[0],b_sr[0],c);
//         a_sr, b_sr shift right (zero fill); sum_sr={s,sum_sr[WIDTH:1]}; cnt++.
//         On the step with cnt==WIDTH (step WIDTH+1), s = final carry -> state=DONE.
//         enable=0 in RUN: stall, all regs hold (no timeout).
//   DONE: done_o=1 for exactly one cycle, then IDLE. load -> RUN (done still 1 this cycle).
//         enable in DONE -> err_o=1, no shift.
//  Latency: load edge + WIDTH+1 enable edges -> done_o high next cycle, sum_o final.
//  sum_o = sum_sr always; mod 2^(WIDTH+1) exact, never overflows.
//  load and enable in the same cycle: load wins, the enable is discarded (no err).
//  load mid-RUN: abort, restart with new operands, no done pulse for the aborted add.
//  rst_i mid-RUN: immediate async clear; no done pulse.
//  Result held in sum_o through IDLE until next load/clear.
// TESTING
//  1 load a=5,b=3; 11 enables -> done_o 1 cycle, sum_o=0x008, busy_o 0 after.
//  2 a=0x3FF,b=0x001 -> sum_o=0x400; sum_bit_o 0 on steps 1-10, 1 on step 11.
//  3 a=0x3FF,b=0x3FF, enable dropped 3 cycles after step 4 -> sum_o=0x7FE, no early done.
//  4 load a=1,b=1; 5 enables; load a=2,b=7; 11 enables -> sum_o=0x009, one done pulse total.
//  5 enable while IDLE after done -> err_o=1, sum_o unchanged; clr_n_i=0 -> err_o=0, sum_o=0.
//  6 rst_i pulsed asynchronously mid-RUN (between edges) -> outputs 0 at once, state IDLE.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake/data bundle between the serial-adder sequencer and its datapath.
interface serial_adder_if #(
  parameter int WIDTH = 10
);
  logic             clr_n_i;
  logic             load_i;
  logic             enable_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH:0]   sum_o;
  logic             sum_bit_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  // Sequencer side: drives strobes and operands, observes results.
  modport master (
    output clr_n_i, load_i, enable_i, a_i, b_i,
    input  sum_o, sum_bit_o, busy_o, done_o, err_o
  );

  // Datapath side.
  modport slave (
    input  clr_n_i, load_i, enable_i, a_i, b_i,
    output sum_o, sum_bit_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/serial_adder_datapath.sv
// Bit-serial adder datapath: LSB-first add through a carry flop, one bit per
// enable strobe, WIDTH+1 steps per add (the last step shifts in the carry-out).
module serial_adder_datapath #(
  parameter int WIDTH = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             s_bit, c_nxt;

  // Full-adder on the current LSBs; once the operands have shifted out this
  // reduces to the carry, which is exactly the final step's sum bit.
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  // Next-state and datapath updates; priority clear > load > enable > hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!bus.clr_n_i) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      c_d     = 1'b0;
      sum_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (bus.load_i) begin
      // Also covers abort mid-RUN and back-to-back start from DONE.
      state_d = S_RUN;
      a_d     = bus.a_i;
      b_d     = bus.b_i;
      c_d     = 1'b0;
      sum_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (bus.enable_i) begin
      if (state_q == S_RUN) begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = c_nxt;
        sum_d = {s_bit, sum_q[WIDTH:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH)) state_d = S_DONE;
      end else begin
        // Stray step outside an add: flag it, never shift.
        err_d = 1'b1;
        if (state_q == S_DONE) state_d = S_IDLE;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers; async reset matches the sync clear values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.sum_o     = sum_q;
  assign bus.sum_bit_o = s_bit;
  assign bus.busy_o    = (state_q == S_RUN);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.err_o     = err_q;
endmodule
